twiddle_mult_sequencer: RTL and testbench

- Streaming controller that drives the shared twiddle-multiplier bank of the 64-point radix-2 DIF FFT.
- It accepts lower-leg butterfly outputs over a valid/ready handshake and tracks sample index and stage.
- It computes the twiddle exponent k per sample and drives the bank's operand, TYPESEL and constant index.
- It registers the product, bypassing the bank when k = 0, and forwards the result with stage tags.

---
 rtl/twiddle_mult_sequencer_pkg.sv | 34 +++
 rtl/twiddle_mult_sequencer_addr_gen.sv | 57 +++++
 rtl/twiddle_mult_sequencer.sv | 113 +++++++++++
 tb/tb_twiddle_mult_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_mult_sequencer_pkg.sv
// Shared FFT definitions for the W64 twiddle path: sizes, Q1.14 word layout, k split.
// No logic; constants, types and a pure helper function only.
// The bank constants are generated against the same k -> {TYPESEL, CIDX} split.
package twiddle_mult_sequencer_pkg;

   localparam int N_POINTS    = 64;
   localparam int LOG2N       = $clog2(N_POINTS);
   localparam int HALF_N      = N_POINTS / 2;
   localparam int DATA_WIDTH  = 32;
   localparam int K_WIDTH     = LOG2N;
   localparam int N_WIDTH     = LOG2N - 1;
   localparam int STAGE_WIDTH = 3;
   localparam logic [STAGE_WIDTH-1:0] LAST_STAGE = STAGE_WIDTH'(LOG2N - 1);

   // Complex word: real in the upper half, imag in the lower half, both Q1.14.
   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } cplx_t;

   // Bank select: octant (TYPESEL) and constant within the octant (CIDX).
   typedef struct packed {
      logic [2:0] typesel;
      logic [2:0] cidx;
   } tw_sel_t;

   function automatic tw_sel_t twiddle_sel(input logic [K_WIDTH-1:0] k);
      tw_sel_t s;
      s.typesel = k[5:3];
      s.cidx    = k[2:0];
      return s;
   endfunction

endpackage

// File: rtl/twiddle_mult_sequencer_addr_gen.sv
// Sample/stage counters and twiddle exponent generation for the accepted sample.
// Combinational k/last/bypass for the current input; counters update on accept.
// Stalls simply by not accepting: counters move only when accept_i is high.
module twiddle_mult_sequencer_addr_gen
   import twiddle_mult_sequencer_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   accept_i,
   input  logic                   sof_i,
   output logic [K_WIDTH-1:0]     k_o,
   output logic [STAGE_WIDTH-1:0] stage_o,
   output logic                   last_o,
   output logic                   bypass_o
);

   logic [N_WIDTH-1:0]     n_q, n_d, n_cur, n_masked;
   logic [STAGE_WIDTH-1:0] stage_q, stage_d, stage_cur;

   // Index of the sample at the input; SOF forces (0,0) so a frame restart needs no flush.
   always_comb begin
      n_cur     = sof_i ? '0 : n_q;
      stage_cur = sof_i ? '0 : stage_q;
      // k = (n & ((32 >> stage) - 1)) << stage; stage 5 masks everything away.
      n_masked  = n_cur & (N_WIDTH'(HALF_N - 1) >> stage_cur);
      k_o       = {1'b0, n_masked} << stage_cur;
      stage_o   = stage_cur;
      last_o    = (n_cur == N_WIDTH'(HALF_N - 1));
      bypass_o  = (k_o == '0);
   end

   // Next counter values: n wraps naturally at 31, stage steps on the last sample.
   always_comb begin
      n_d     = n_q;
      stage_d = stage_q;
      if (accept_i) begin
         n_d = n_cur + 1'b1;
         if (last_o) begin
            stage_d = (stage_cur == LAST_STAGE) ? '0 : stage_cur + 1'b1;
         end else begin
            stage_d = stage_cur;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         n_q     <= '0;
         stage_q <= '0;
      end else begin
         n_q     <= n_d;
         stage_q <= stage_d;
      end
   end

endmodule

// File: rtl/twiddle_mult_sequencer.sv
// Drives the shared W64 twiddle-multiplier bank and forwards tagged products.
// Latency 2 cycles accept-to-OUT_VALID; one sample per cycle sustained.
// Two-entry pipe; IN_READY drops only with both entries full and OUT_READY low.
module twiddle_mult_sequencer
   import twiddle_mult_sequencer_pkg::*;
(
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   input  logic                   IN_SOF,
   input  logic [DATA_WIDTH-1:0]  IN_DATA,
   output logic [DATA_WIDTH-1:0]  MULT_A32,
   output logic [2:0]             MULT_TYPESEL,
   output logic [2:0]             MULT_CIDX,
   input  logic [DATA_WIDTH-1:0]  MULT_R32,
   output logic                   OUT_VALID,
   input  logic                   OUT_READY,
   output logic [DATA_WIDTH-1:0]  OUT_DATA,
   output logic                   OUT_SOF,
   output logic [STAGE_WIDTH-1:0] OUT_STAGE,
   output logic                   OUT_LAST
);

   logic                   accept, adv_b, move_ab;
   logic [K_WIDTH-1:0]     gen_k;
   logic [STAGE_WIDTH-1:0] gen_stage;
   logic                   gen_last, gen_bypass;
   tw_sel_t                sel;

   // Stage A: operand presented to the bank.
   logic                   a_vld_q, a_sof_q, a_last_q, a_byp_q;
   cplx_t                  a_dat_q;
   logic [K_WIDTH-1:0]     a_k_q;
   logic [STAGE_WIDTH-1:0] a_stage_q;

   // Stage B: registered product, drives OUT_*.
   logic                   b_vld_q, b_sof_q, b_last_q;
   cplx_t                  b_dat_q;
   logic [STAGE_WIDTH-1:0] b_stage_q;

   // IN_READY depends only on pipe state, never on IN_VALID.
   assign adv_b    = ~b_vld_q | OUT_READY;
   assign move_ab  = a_vld_q & adv_b;
   assign IN_READY = ~a_vld_q | adv_b;
   assign accept   = IN_VALID & IN_READY;

   twiddle_mult_sequencer_addr_gen u_addr_gen (
      .clk_i    (CLK),
      .rst_i    (RST),
      .accept_i (accept),
      .sof_i    (IN_SOF),
      .k_o      (gen_k),
      .stage_o  (gen_stage),
      .last_o   (gen_last),
      .bypass_o (gen_bypass)
   );

   // Bank inputs come straight from A, so they hold while A is stalled.
   assign sel          = twiddle_sel(a_k_q);
   assign MULT_A32     = a_dat_q;
   assign MULT_TYPESEL = sel.typesel;
   assign MULT_CIDX    = sel.cidx;

   assign OUT_VALID = b_vld_q;
   assign OUT_DATA  = b_dat_q;
   assign OUT_SOF   = b_sof_q;
   assign OUT_STAGE = b_stage_q;
   assign OUT_LAST  = b_last_q;

   // Stage A: capture sample and its twiddle tags on accept.
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_vld_q   <= 1'b0;
         a_dat_q   <= '0;
         a_k_q     <= '0;
         a_sof_q   <= 1'b0;
         a_stage_q <= '0;
         a_last_q  <= 1'b0;
         a_byp_q   <= 1'b0;
      end else begin
         a_vld_q <= accept | (a_vld_q & ~move_ab);
         if (accept) begin
            a_dat_q   <= IN_DATA;
            a_k_q     <= gen_k;
            a_sof_q   <= IN_SOF;
            a_stage_q <= gen_stage;
            a_last_q  <= gen_last;
            a_byp_q   <= gen_bypass;
         end
      end
   end

   // Stage B: register the product (or the raw sample when k is 0) with its tags.
   always_ff @(posedge CLK) begin
      if (RST) begin
         b_vld_q   <= 1'b0;
         b_dat_q   <= '0;
         b_sof_q   <= 1'b0;
         b_stage_q <= '0;
         b_last_q  <= 1'b0;
      end else begin
         b_vld_q <= move_ab | (b_vld_q & ~OUT_READY);
         if (move_ab) begin
            b_dat_q   <= a_byp_q ? a_dat_q : MULT_R32;
            b_sof_q   <= a_sof_q;
            b_stage_q <= a_stage_q;
            b_last_q  <= a_last_q;
         end
      end
   end

endmodule

// File: tb/tb_twiddle_mult_sequencer.sv
// Directed bench for twiddle_mult_sequencer with a behavioural multiplier bank.
// The bank returns ~A ^ k so a wrong bypass decision is visible even for k = 0.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_twiddle_mult_sequencer;

   logic        CLK = 1'b0;
   logic        RST;
   logic        IN_VALID, IN_READY, IN_SOF;
   logic [31:0] IN_DATA;
   logic [31:0] MULT_A32, MULT_R32;
   logic [2:0]  MULT_TYPESEL, MULT_CIDX;
   logic        OUT_VALID, OUT_READY, OUT_SOF, OUT_LAST;
   logic [31:0] OUT_DATA;
   logic [2:0]  OUT_STAGE;

   int checks = 0;
   int errors = 0;

   // stimulus and capture storage
   logic [31:0] in_dat    [256];
   logic        in_sof_a  [256];
   int          n_in;
   logic [31:0] cap_dat   [256];
   logic        cap_sof   [256];
   logic [2:0]  cap_stage [256];
   logic        cap_last  [256];
   logic [2:0]  m_ts      [256];
   logic [2:0]  m_ci      [256];
   int          cap_cnt, stall_bad, rdy_bad, cyc_first_acc, cyc_first_out;

   always #5 CLK = ~CLK;

   assign MULT_R32 = ~MULT_A32 ^ {26'd0, MULT_TYPESEL, MULT_CIDX};

   twiddle_mult_sequencer dut (
      .CLK          (CLK),
      .RST          (RST),
      .IN_VALID     (IN_VALID),
      .IN_READY     (IN_READY),
      .IN_SOF       (IN_SOF),
      .IN_DATA      (IN_DATA),
      .MULT_A32     (MULT_A32),
      .MULT_TYPESEL (MULT_TYPESEL),
      .MULT_CIDX    (MULT_CIDX),
      .MULT_R32     (MULT_R32),
      .OUT_VALID    (OUT_VALID),
      .OUT_READY    (OUT_READY),
      .OUT_DATA     (OUT_DATA),
      .OUT_SOF      (OUT_SOF),
      .OUT_STAGE    (OUT_STAGE),
      .OUT_LAST     (OUT_LAST)
   );

   // k from the stage/index definition, written as modulo and multiply
   function automatic logic [5:0] exp_k(input int n, input int s);
      int m;
      m = 32 >> s;
      return 6'((n % m) * (1 << s));
   endfunction

   function automatic logic [31:0] exp_out(input logic [31:0] d, input logic [5:0] k);
      return (k == 6'd0) ? d : (~d ^ {26'd0, k});
   endfunction

   // Streams in_dat[0..n_in-1] and records outputs; bp=1 randomises OUT_READY.
   task automatic run(input int bp, input int max_cyc);
      int sent = 0;
      int pend = -1;
      int cyc = 0;
      logic [31:0] hold_d;
      logic [2:0]  hold_s;
      logic stalled = 1'b0;
      cap_cnt = 0; stall_bad = 0; rdy_bad = 0; cyc_first_acc = -1; cyc_first_out = -1;
      IN_VALID  = (n_in > 0);
      IN_DATA   = in_dat[0];
      IN_SOF    = in_sof_a[0];
      OUT_READY = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      while ((sent < n_in || cap_cnt < n_in) && cyc < max_cyc) begin
         @(negedge CLK);
         if (pend >= 0) begin
            m_ts[pend] = MULT_TYPESEL;
            m_ci[pend] = MULT_CIDX;
            pend = -1;
         end
         if (stalled && (OUT_DATA !== hold_d || OUT_STAGE !== hold_s || OUT_VALID !== 1'b1))
            stall_bad++;
         if (IN_READY === 1'b0 && !(OUT_VALID === 1'b1 && OUT_READY === 1'b0))
            rdy_bad++;
         if (OUT_VALID === 1'b1 && OUT_READY === 1'b1 && cap_cnt < 256) begin
            if (cyc_first_out < 0) cyc_first_out = cyc;
            cap_dat[cap_cnt]   = OUT_DATA;
            cap_sof[cap_cnt]   = OUT_SOF;
            cap_stage[cap_cnt] = OUT_STAGE;
            cap_last[cap_cnt]  = OUT_LAST;
            cap_cnt++;
         end
         stalled = (OUT_VALID === 1'b1 && OUT_READY === 1'b0);
         hold_d  = OUT_DATA;
         hold_s  = OUT_STAGE;
         if (IN_VALID === 1'b1 && IN_READY === 1'b1) begin
            if (sent == 0) cyc_first_acc = cyc;
            pend = sent;
            sent++;
         end
         @(posedge CLK); #1;
         cyc++;
         IN_VALID = (sent < n_in);
         if (sent < n_in) begin
            IN_DATA = in_dat[sent];
            IN_SOF  = in_sof_a[sent];
         end else begin
            IN_SOF = 1'b0;
         end
         OUT_READY = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      IN_VALID = 1'b0;
      IN_SOF   = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; IN_VALID = 1'b0; IN_SOF = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", IN_READY); end
      checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", OUT_VALID); end
      checks++; if (OUT_DATA !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", OUT_DATA); end
      checks++; if (MULT_TYPESEL !== 3'd0) begin errors++; $display("FAIL reset_typesel got %0d exp 0", MULT_TYPESEL); end
      checks++; if (MULT_CIDX !== 3'd0) begin errors++; $display("FAIL reset_cidx got %0d exp 0", MULT_CIDX); end
      checks++; if (MULT_A32 !== 32'h0) begin errors++; $display("FAIL reset_mult_a got %h exp 0", MULT_A32); end
      @(posedge CLK); #1;
   endtask

   task automatic test_stage0();
      n_in = 32;
      for (int i = 0; i < 32; i++) begin
         in_dat[i]   = {16'(16'h0100 + i), 16'(16'h8000 ^ i)};
         in_sof_a[i] = (i == 0);
      end
      in_dat[0] = 32'h4000_C000;
      run(0, 500);
      checks++; if (cap_cnt !== 32) begin errors++; $display("FAIL s0_count got %0d exp 32", cap_cnt); end
      checks++; if (m_ts[5] !== 3'd0 || m_ci[5] !== 3'd5) begin errors++; $display("FAIL s0_n5_sel got %0d/%0d exp 0/5", m_ts[5], m_ci[5]); end
      checks++; if (m_ts[31] !== 3'd3 || m_ci[31] !== 3'd7) begin errors++; $display("FAIL s0_n31_sel got %0d/%0d exp 3/7", m_ts[31], m_ci[31]); end
      checks++; if (cyc_first_out - cyc_first_acc !== 2) begin errors++; $display("FAIL s0_latency got %0d exp 2", cyc_first_out - cyc_first_acc); end
      checks++; if (cap_dat[0] !== 32'h4000_C000) begin errors++; $display("FAIL s0_bypass_n0 got %h exp 4000c000", cap_dat[0]); end
      checks++; if (cap_sof[0] !== 1'b1) begin errors++; $display("FAIL s0_sof got %b exp 1", cap_sof[0]); end
      checks++; if (cap_last[31] !== 1'b1 || cap_stage[31] !== 3'd0) begin errors++; $display("FAIL s0_last got %b/%0d exp 1/0", cap_last[31], cap_stage[31]); end
      // stage 0: k equals n
      for (int i = 1; i < 32; i++) begin
         checks++;
         if (cap_dat[i] !== (~in_dat[i] ^ 32'(i))) begin
            errors++; $display("FAIL s0_data[%0d] got %h exp %h", i, cap_dat[i], ~in_dat[i] ^ 32'(i));
         end
      end
   endtask

   task automatic test_frame();
      n_in = 193;
      for (int i = 0; i < 193; i++) begin
         in_dat[i]   = {16'(i * 7), 16'(16'h5A5A ^ i)};
         in_sof_a[i] = (i == 0);
      end
      run(0, 1000);
      checks++; if (cap_cnt !== 193) begin errors++; $display("FAIL frame_count got %0d exp 193", cap_cnt); end
      checks++; if (m_ts[52] !== 3'd1 || m_ci[52] !== 3'd0) begin errors++; $display("FAIL frame_s1n20_sel got %0d/%0d exp 1/0", m_ts[52], m_ci[52]); end
      checks++; if (cap_dat[52] !== (~in_dat[52] ^ 32'd8)) begin errors++; $display("FAIL frame_s1n20_data got %h exp %h", cap_dat[52], ~in_dat[52] ^ 32'd8); end
      for (int i = 160; i < 192; i++) begin
         checks++;
         if (cap_dat[i] !== in_dat[i]) begin errors++; $display("FAIL frame_s5_bypass[%0d] got %h exp %h", i, cap_dat[i], in_dat[i]); end
      end
      checks++; if (cap_stage[192] !== 3'd0 || cap_sof[192] !== 1'b0) begin errors++; $display("FAIL frame_wrap got stage %0d sof %b exp 0/0", cap_stage[192], cap_sof[192]); end
      checks++; if (cap_dat[192] !== in_dat[192]) begin errors++; $display("FAIL frame_wrap_data got %h exp %h", cap_dat[192], in_dat[192]); end
      for (int i = 0; i < 192; i++) begin
         checks++;
         if (cap_dat[i] !== exp_out(in_dat[i], exp_k(i % 32, i / 32)) || cap_stage[i] !== 3'(i / 32)
             || cap_last[i] !== ((i % 32) == 31) || cap_sof[i] !== (i == 0)) begin
            errors++;
            $display("FAIL frame_sample[%0d] got %h st%0d l%b s%b exp %h st%0d", i, cap_dat[i], cap_stage[i],
                     cap_last[i], cap_sof[i], exp_out(in_dat[i], exp_k(i % 32, i / 32)), i / 32);
         end
      end
   endtask

   task automatic test_backpressure();
      n_in = 192;
      for (int i = 0; i < 192; i++) begin
         in_dat[i]   = $urandom;
         in_sof_a[i] = (i == 0);
      end
      run(1, 3000);
      checks++; if (cap_cnt !== 192) begin errors++; $display("FAIL bp_count got %0d exp 192", cap_cnt); end
      checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_hold got %0d changes exp 0", stall_bad); end
      checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL bp_in_ready got %0d bad cycles exp 0", rdy_bad); end
      for (int i = 0; i < 192; i++) begin
         checks++;
         if (cap_dat[i] !== exp_out(in_dat[i], exp_k(i % 32, i / 32)) || cap_stage[i] !== 3'(i / 32)
             || cap_last[i] !== ((i % 32) == 31)) begin
            errors++;
            $display("FAIL bp_sample[%0d] got %h st%0d exp %h st%0d", i, cap_dat[i], cap_stage[i],
                     exp_out(in_dat[i], exp_k(i % 32, i / 32)), i / 32);
         end
      end
   endtask

   task automatic test_resync();
      n_in = 78;
      for (int i = 0; i < 78; i++) begin
         in_dat[i]   = {16'(16'h1000 + i), 16'(16'hF00F ^ (i * 3))};
         in_sof_a[i] = (i == 0) || (i == 74);
      end
      run(0, 500);
      checks++; if (cap_cnt !== 78) begin errors++; $display("FAIL rs_count got %0d exp 78", cap_cnt); end
      // stage 2, n=9 -> k=4
      checks++; if (m_ts[73] !== 3'd0 || m_ci[73] !== 3'd4 || cap_stage[73] !== 3'd2) begin errors++; $display("FAIL rs_pre got %0d/%0d st%0d exp 0/4 st2", m_ts[73], m_ci[73], cap_stage[73]); end
      checks++; if (m_ts[74] !== 3'd0 || m_ci[74] !== 3'd0) begin errors++; $display("FAIL rs_sof_sel got %0d/%0d exp 0/0", m_ts[74], m_ci[74]); end
      checks++; if (cap_sof[74] !== 1'b1 || cap_stage[74] !== 3'd0) begin errors++; $display("FAIL rs_sof_tags got %b/%0d exp 1/0", cap_sof[74], cap_stage[74]); end
      checks++; if (cap_dat[74] !== in_dat[74]) begin errors++; $display("FAIL rs_sof_data got %h exp %h", cap_dat[74], in_dat[74]); end
      checks++; if (m_ci[75] !== 3'd1 || cap_stage[75] !== 3'd0) begin errors++; $display("FAIL rs_next got ci %0d st%0d exp 1/0", m_ci[75], cap_stage[75]); end
      checks++; if (cap_dat[75] !== (~in_dat[75] ^ 32'd1)) begin errors++; $display("FAIL rs_next_data got %h exp %h", cap_dat[75], ~in_dat[75] ^ 32'd1); end
   endtask

   task automatic test_reset_inflight();
      int seen = 0;
      OUT_READY = 1'b0; IN_VALID = 1'b1; IN_SOF = 1'b1; IN_DATA = 32'h1111_2222;
      @(posedge CLK); #1;
      IN_SOF = 1'b0; IN_DATA = 32'h3333_4444;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      @(negedge CLK);
      checks++; if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin errors++; $display("FAIL rst_full got v%b r%b exp v1 r0", OUT_VALID, IN_READY); end
      @(posedge CLK); #1 RST = 1'b1;
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      checks++; if (OUT_VALID !== 1'b0 || OUT_DATA !== 32'h0) begin errors++; $display("FAIL rst_flush got v%b %h exp v0 0", OUT_VALID, OUT_DATA); end
      checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", IN_READY); end
      @(posedge CLK); #1 OUT_READY = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         if (OUT_VALID === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_ghost got %0d outputs exp 0", seen); end
      @(posedge CLK); #1;
      n_in = 1; in_dat[0] = 32'h0BAD_F00D; in_sof_a[0] = 1'b1;
      run(0, 100);
      checks++; if (cap_cnt !== 1 || cap_dat[0] !== 32'h0BAD_F00D || cap_sof[0] !== 1'b1) begin
         errors++; $display("FAIL rst_after got cnt %0d %h exp 1 0badf00d", cap_cnt, cap_dat[0]);
      end
   endtask

   initial begin
      test_reset();
      test_stage0();
      test_frame();
      test_backpressure();
      test_resync();
      test_reset_inflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
